// File: rtl/output_vc_arbiter_pkg.sv
// rtl/output_vc_arbiter_pkg.sv - shared constants and types for the output VC arbiter
// Purpose : requester indices, VC identifiers and per-VC FSM state encoding.
// Ports   : none (package).
// Config  : OUT_ARB_STATS_EN (used by output_vc_arbiter) enables grant statistics.
package output_vc_arbiter_pkg;

  // Requester indices in the request/grant vectors.
  localparam int REQ_CW  = 0;
  localparam int REQ_CCW = 1;
  localparam int REQ_PE  = 2;

  // Legal requester count range.
  localparam int MIN_REQ = 2;
  localparam int MAX_REQ = 4;

  // Virtual channel identifiers (also the polarity value that selects them).
  localparam logic VC0 = 1'b0;
  localparam logic VC1 = 1'b1;

  // Per-VC FSM: GRANTED blocks further grants until the VC is selected again.
  typedef enum logic {
    VC_IDLE    = 1'b0,
    VC_GRANTED = 1'b1
  } vc_state_t;

  // Pointer / index width for a given requester count (at least 1 bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/output_vc_arbiter_if.sv
// rtl/output_vc_arbiter_if.sv - request/grant bundle between requesters and the output VC arbiter
// Purpose : groups phase, per-VC requests, buffer status, grant and statistics signals.
// Ports   : polarity, req_vc0[NUM_REQ], req_vc1[NUM_REQ], obuf_full[2] (requester -> arbiter);
//           gnt[NUM_REQ], gnt_vc, gnt_valid, stat_cnt[NUM_REQ*CNT_W] (arbiter -> requester).
// Modports: master = requester/router side, slave = arbiter side.
interface output_vc_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int CNT_W   = 16
);

  logic                     polarity;
  logic [NUM_REQ-1:0]       req_vc0;
  logic [NUM_REQ-1:0]       req_vc1;
  logic [1:0]               obuf_full;
  logic [NUM_REQ-1:0]       gnt;
  logic                     gnt_vc;
  logic                     gnt_valid;
  logic [NUM_REQ*CNT_W-1:0] stat_cnt;

  modport master (
    output polarity, req_vc0, req_vc1, obuf_full,
    input  gnt, gnt_vc, gnt_valid, stat_cnt
  );

  modport slave (
    input  polarity, req_vc0, req_vc1, obuf_full,
    output gnt, gnt_vc, gnt_valid, stat_cnt
  );

endinterface

// File: rtl/output_vc_arbiter_rr_pick.sv
// rtl/output_vc_arbiter_rr_pick.sv - combinational round-robin search
// Purpose : finds the first set request at or above ptr, wrapping N-1 -> 0.
// Ports   : req[N] request vector, ptr[IDX_W] search start;
//           onehot[N] winner one-hot, idx[IDX_W] winner index, any = some request set.
module rr_pick
  import output_vc_arbiter_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int              pos;
    logic [IDX_W-1:0] cand;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    pos    = 0;
    cand   = '0;
    for (int i = 0; i < N; i++) begin
      pos = int'(ptr) + i;
      if (pos >= N) pos = pos - N;
      cand = IDX_W'(pos);
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_vc_arbiter.sv
// rtl/output_vc_arbiter.sv - two-VC output port arbiter with per-VC round-robin
// Purpose : each cycle arbitrates the VC selected by polarity; registered one-hot grant,
//           independent round-robin pointers per VC, per-VC IDLE/GRANTED FSM.
// Ports   : clk, reset (async, active-low), bus (output_vc_arbiter_if.slave).
// Config  : OUT_ARB_STATS_EN defined -> saturating per-requester grant counters on
//           bus.stat_cnt; undefined -> stat_cnt driven 0, no counter flops.
module output_vc_arbiter
  import output_vc_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  output_vc_arbiter_if.slave    bus
);

  localparam int IDX_W = idx_width(NUM_REQ);

  // Per-VC search results.
  logic [NUM_REQ-1:0] pick_onehot [2];
  logic [IDX_W-1:0]   pick_idx    [2];
  logic               pick_any    [2];

  // State.
  vc_state_t          state_q [2];
  vc_state_t          state_d [2];
  logic [IDX_W-1:0]   rr_ptr_q [2];
  logic               prev_pol_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic               gnt_vc_q;
  logic               gnt_valid_q;

  // Decision for the active VC.
  logic               sel;
  logic               blocked;
  logic               grant_d;
  logic [NUM_REQ-1:0] win_onehot;
  logic [IDX_W-1:0]   ptr_next;

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick_vc0 (
    .req    (bus.req_vc0),
    .ptr    (rr_ptr_q[0]),
    .onehot (pick_onehot[0]),
    .idx    (pick_idx[0]),
    .any    (pick_any[0])
  );

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick_vc1 (
    .req    (bus.req_vc1),
    .ptr    (rr_ptr_q[1]),
    .onehot (pick_onehot[1]),
    .idx    (pick_idx[1]),
    .any    (pick_any[1])
  );

  // A GRANTED VC stays blocked while polarity keeps selecting it; the first edge
  // that re-selects it after a phase change releases it and may grant again.
  always_comb begin
    int nxt;
    sel        = bus.polarity;
    blocked    = (state_q[sel] == VC_GRANTED) && (prev_pol_q == sel);
    grant_d    = !bus.obuf_full[sel] && pick_any[sel] && !blocked;
    win_onehot = pick_onehot[sel];
    nxt        = int'(pick_idx[sel]) + 1;
    if (nxt >= NUM_REQ) nxt = 0;
    ptr_next   = IDX_W'(nxt);
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    if (grant_d) begin
      state_d[sel] = VC_GRANTED;
    end else if (state_q[sel] == VC_GRANTED && !blocked) begin
      state_d[sel] = VC_IDLE;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q[0] <= VC_IDLE;
      state_q[1] <= VC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant, pointer and phase registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_q       <= '0;
      gnt_vc_q    <= VC0;
      gnt_valid_q <= 1'b0;
      rr_ptr_q[0] <= '0;
      rr_ptr_q[1] <= '0;
      prev_pol_q  <= VC0;
    end else begin
      prev_pol_q <= sel;
      if (grant_d) begin
        gnt_q         <= win_onehot;
        gnt_vc_q      <= sel;
        gnt_valid_q   <= 1'b1;
        rr_ptr_q[sel] <= ptr_next;
      end else begin
        // gnt_vc keeps the VC of the last grant.
        gnt_q       <= '0;
        gnt_valid_q <= 1'b0;
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_vc    = gnt_vc_q;
  assign bus.gnt_valid = gnt_valid_q;

`ifdef OUT_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [NUM_REQ];

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_stat
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q[r] <= '0;
      end else if (grant_d && win_onehot[r] && (cnt_q[r] != {CNT_W{1'b1}})) begin
        cnt_q[r] <= cnt_q[r] + 1'b1;
      end
    end
    assign bus.stat_cnt[r*CNT_W +: CNT_W] = cnt_q[r];
  end
`else
  assign bus.stat_cnt = '0;
`endif

endmodule

// File: tb/tb_output_vc_arbiter.sv
// tb/tb_output_vc_arbiter.sv - self-checking bench for output_vc_arbiter
module tb_output_vc_arbiter;

  localparam int NR = 3;
`ifdef OUT_ARB_STATS_EN
  localparam int CW = 4;
  localparam logic [CW-1:0] EXP_R2 = 4'd15;
`else
  localparam int CW = 16;
  localparam logic [CW-1:0] EXP_R2 = '0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  output_vc_arbiter_if #(.NUM_REQ(NR), .CNT_W(CW)) bus ();

  output_vc_arbiter #(.NUM_REQ(NR), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       pol;
    logic [2:0] r0;
    logic [2:0] r1;
    logic [1:0] full;
    logic [2:0] gnt;
    logic       vc;
    logic       valid;
  } vec_t;

  vec_t vecs [21];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] g, input logic vc, input logic v);
    check({tag, ".gnt"},       64'(bus.gnt),       64'(g));
    check({tag, ".gnt_vc"},    64'(bus.gnt_vc),    64'(vc));
    check({tag, ".gnt_valid"}, 64'(bus.gnt_valid), 64'(v));
  endtask

  task automatic drive(input logic pol, input logic [2:0] r0, input logic [2:0] r1,
                       input logic [1:0] f);
    bus.polarity  = pol;
    bus.req_vc0   = r0;
    bus.req_vc1   = r1;
    bus.obuf_full = f;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // {pol, req_vc0, req_vc1, obuf_full, exp gnt, exp gnt_vc, exp gnt_valid}
    // VC0 rotation with polarity toggling every cycle
    vecs[0]  = '{1'b0, 3'b111, 3'b000, 2'b00, 3'b001, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 3'b111, 3'b000, 2'b00, 3'b000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 3'b111, 3'b000, 2'b00, 3'b010, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 3'b111, 3'b000, 2'b00, 3'b000, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 3'b111, 3'b000, 2'b00, 3'b100, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 3'b111, 3'b000, 2'b00, 3'b000, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 3'b111, 3'b000, 2'b00, 3'b001, 1'b0, 1'b1};
    // VC1 request held off by full buffer for three VC1 phases
    vecs[7]  = '{1'b1, 3'b000, 3'b010, 2'b10, 3'b000, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 3'b000, 3'b010, 2'b10, 3'b000, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 3'b000, 3'b010, 2'b10, 3'b000, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 3'b000, 3'b010, 2'b10, 3'b000, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 3'b000, 3'b010, 2'b10, 3'b000, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 3'b000, 3'b010, 2'b00, 3'b000, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 3'b000, 3'b010, 2'b00, 3'b010, 1'b1, 1'b1};
    // simultaneous requests on both VCs (ptr0=1, ptr1=2 on entry)
    vecs[14] = '{1'b0, 3'b100, 3'b001, 2'b00, 3'b100, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 3'b100, 3'b001, 2'b00, 3'b001, 1'b1, 1'b1};
    vecs[16] = '{1'b0, 3'b000, 3'b000, 2'b00, 3'b000, 1'b1, 1'b0};
    // pointers now ptr1=1, ptr0=0
    vecs[17] = '{1'b1, 3'b000, 3'b111, 2'b00, 3'b010, 1'b1, 1'b1};
    vecs[18] = '{1'b0, 3'b111, 3'b000, 2'b00, 3'b001, 1'b0, 1'b1};
    // other VC full is ignored; active VC full blocks
    vecs[19] = '{1'b1, 3'b111, 3'b111, 2'b01, 3'b100, 1'b1, 1'b1};
    vecs[20] = '{1'b0, 3'b111, 3'b111, 2'b01, 3'b000, 1'b1, 1'b0};

    // Reset state
    reset = 1'b0;
    drive(1'b0, 3'b000, 3'b000, 2'b00);
    tick;
    tick;
    check_out("reset", 3'b000, 1'b0, 1'b0);
    check("reset.stat_cnt", 64'(bus.stat_cnt), 64'd0);
    reset = 1'b1;

    // Table
    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].pol, vecs[i].r0, vecs[i].r1, vecs[i].full);
      tick;
      check_out($sformatf("vec[%0d]", i), vecs[i].gnt, vecs[i].vc, vecs[i].valid);
    end
    // State here: ptr0=1, ptr1=0, VC1 GRANTED, last polarity 0.

    // Stale request with polarity held on VC0: one grant, then blocked
    drive(1'b0, 3'b010, 3'b000, 2'b00);
    tick;
    check_out("stale.first", 3'b010, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick;
      check_out($sformatf("stale.hold[%0d]", i), 3'b000, 1'b0, 1'b0);
    end
    drive(1'b1, 3'b010, 3'b000, 2'b00);
    tick;
    check_out("stale.vc1", 3'b000, 1'b0, 1'b0);
    drive(1'b0, 3'b010, 3'b000, 2'b00);
    tick;
    check_out("stale.regrant", 3'b010, 1'b0, 1'b1);

    // Reset mid-grant: ptr0=2 so requester 2 wins first
    drive(1'b1, 3'b111, 3'b000, 2'b00);
    tick;
    drive(1'b0, 3'b111, 3'b000, 2'b00);
    tick;
    check_out("midrst.pre", 3'b100, 1'b0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_out("midrst.async", 3'b000, 1'b0, 1'b0);
    tick;
    check_out("midrst.held", 3'b000, 1'b0, 1'b0);
    #1;
    reset = 1'b1;
    tick;
    check_out("midrst.vc0first", 3'b001, 1'b0, 1'b1);
    drive(1'b1, 3'b000, 3'b111, 2'b00);
    tick;
    check_out("midrst.vc1first", 3'b001, 1'b1, 1'b1);

    // Statistics: 20 grants to requester 2 from a fresh reset
    reset = 1'b0;
    drive(1'b0, 3'b000, 3'b000, 2'b00);
    tick;
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drive(i[0], 3'b100, 3'b000, 2'b00);
      tick;
      if (i[0] == 1'b0 && (i == 0 || i == 38)) begin
        check_out($sformatf("stats.g[%0d]", i), 3'b100, 1'b0, 1'b1);
      end
    end
    check("stats.r0", 64'(bus.stat_cnt[0*CW +: CW]), 64'd0);
    check("stats.r1", 64'(bus.stat_cnt[1*CW +: CW]), 64'd0);
    check("stats.r2", 64'(bus.stat_cnt[2*CW +: CW]), 64'(EXP_R2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/output_vc_arbiter.md
OUTPUT_VC_ARBITER -- requirements
Module: output_vc_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of requesters (0=cw input, 1=ccw input, 2=PE input); legal range 2..4.
REQ-002 Parameter CNT_W, default 16, width of each grant statistic counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-low.
REQ-005 polarity  input  1  router phase; VC currently arbitrated equals polarity.
REQ-006 req_vc0  input  NUM_REQ  per-requester "head packet for VC0 pending".
REQ-007 req_vc1  input  NUM_REQ  per-requester "head packet for VC1 pending".
REQ-008 obuf_full  input  2  output buffer occupied, bit v = VC v.
REQ-009 gnt  output  NUM_REQ  registered one-hot grant.
REQ-010 gnt_vc  output  1  VC the current grant belongs to.
REQ-011 gnt_valid  output  1  high when gnt is non-zero.
REQ-012 stat_cnt  output  NUM_REQ*CNT_W  grant counters, requester r at bits [r*CNT_W +: CNT_W].

Function
REQ-013 Active VC p SHALL equal polarity sampled at the same rising edge.
REQ-014 At each edge, arbiter SHALL grant iff obuf_full[p]==0 and req_vc<p> has at least one bit set.
REQ-015 Winner SHALL be the first set request found searching upward from rr_ptr[p], wrapping NUM_REQ-1 -> 0.
REQ-016 On grant: gnt<=onehot(winner), gnt_vc<=p, gnt_valid<=1, rr_ptr[p]<=(winner+1) mod NUM_REQ.
REQ-017 No grant: gnt<=0, gnt_valid<=0, gnt_vc holds its previous value, pointers unchanged.
REQ-018 Latency: request sampled at edge k produces grant visible for exactly one cycle after edge k.
REQ-019 Per-VC FSM {IDLE, GRANTED}: IDLE->GRANTED on grant for that VC; GRANTED->IDLE on next edge where polarity selects that VC again; while GRANTED that VC SHALL NOT be granted even if obuf_full lags.
REQ-020 Requesters SHALL drop the granted request before the next edge selecting the same VC; arbiter need not filter stale requests beyond REQ-019.
REQ-021 Simultaneous requests on both VCs: only VC p considered; other VC waits for polarity toggle.
REQ-022 Pointers of VC0 and VC1 SHALL be independent.
REQ-023 Back-to-back: with all requesters continuously asserting and buffers free, grants for a VC SHALL rotate 0,1,2,0,... every second cycle.

Reset
REQ-024 While reset low: gnt=0, gnt_valid=0, gnt_vc=0, both FSMs IDLE, both rr_ptr=0, stat_cnt=0.
REQ-025 Reset assertion mid-grant SHALL clear gnt within the same cycle (asynchronous); first grant possible at first edge after release.

Configuration
REQ-026 Macro OUT_ARB_STATS_EN: when defined, stat_cnt[r] SHALL increment by 1 on each grant to r, saturating at all-ones.
REQ-027 Without OUT_ARB_STATS_EN, stat_cnt port SHALL remain present and be driven constant 0, no counter flops.

Structure
REQ-028 Shared package SHALL hold requester index constants (REQ_CW=0, REQ_CCW=1, REQ_PE=2), VC constants and FSM state encoding.
REQ-029 One sub-module rr_pick (combinational round-robin search: request vector + pointer -> one-hot + index) SHALL be instantiated once per VC.

Verification
REQ-030 All three request VC0, polarity=0 phases, obuf_full=00 -> gnt 001,010,100,001 on consecutive VC0 phases, gnt_vc=0.
REQ-031 req_vc1=010, obuf_full=10 for 3 phases then 00 -> no grant while full, gnt=010 gnt_vc=1 one cycle after first free VC1 phase.
REQ-032 req_vc0=100 and req_vc1=001 together -> VC0 phase grants 100, VC1 phase grants 001; pointers end rr_ptr[0]=0, rr_ptr[1]=1.
REQ-033 Grant issued, obuf_full held 0 stale, requester keeps req -> FSM GRANTED blocks; no second grant in that VC phase.
REQ-034 Drive reset low mid-grant -> gnt=0 immediately; after release pointers restart at 0 (requester 0 wins first).
REQ-035 With OUT_ARB_STATS_EN, CNT_W=4, 20 grants to requester 2 -> stat_cnt[2]=15, others 0; without macro stat_cnt=0.
